// File: rtl/mem_port_arbiter_pkg.sv
// defs: constants and types shared by the memory port arbiter.
// STARVE_MAX is only consumed when MEM_ARB_FAIRNESS_EN is defined.
package defs;

    localparam int MEM_SIZE   = 4000;
    localparam int BIN_DIG    = 32;
    localparam int MEM_ADDR_W = $clog2(MEM_SIZE);
    localparam int STARVE_MAX = 4;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } arb_owner_t;

    typedef struct packed {
        arb_owner_t own;
        logic       err;
        logic       zero;
    } arb_resp_t;

endpackage

// File: rtl/arb_starve_cnt.sv
// arb_starve_cnt: saturating count of consecutive fetch losses.
// Built only when MEM_ARB_FAIRNESS_EN is defined.
`ifdef MEM_ARB_FAIRNESS_EN
module arb_starve_cnt
    import defs::*;
#(
    parameter int MAX = STARVE_MAX
)(
    input  logic clk,
    input  logic rst_n,
    input  logic req,
    input  logic win,
    output logic hit
);

    localparam int W = $clog2(MAX + 1);

    logic [W-1:0] cnt;

    assign hit = (cnt == W'(MAX));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!req || win) begin
            cnt <= '0;
        end else if (!hit) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule
`endif

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one word-wide memory between fetch and LSU.
// Data wins by default; MEM_ARB_FAIRNESS_EN lets a starved fetch win.
module mem_port_arbiter
    import defs::*;
#(
    parameter int MEM_SIZE = defs::MEM_SIZE,
    parameter int XLEN     = BIN_DIG
)(
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        if_req,
    input  logic [XLEN-1:0]             if_addr,
    output logic                        if_gnt,
    output logic                        if_rvalid,
    output logic [XLEN-1:0]             if_rdata,
    output logic                        if_err,
    input  logic                        d_req,
    input  logic                        d_we,
    input  logic [XLEN-1:0]             d_addr,
    input  logic [3:0]                  d_be,
    input  logic [XLEN-1:0]             d_wdata,
    output logic                        d_gnt,
    output logic                        d_rvalid,
    output logic [XLEN-1:0]             d_rdata,
    output logic                        d_err,
    output logic                        mem_en,
    output logic                        mem_we,
    output logic [3:0]                  mem_be,
    output logic [$clog2(MEM_SIZE)-1:0] mem_addr,
    output logic [XLEN-1:0]             mem_wdata,
    input  logic [XLEN-1:0]             mem_rdata
);

    localparam int              AW  = $clog2(MEM_SIZE);
    localparam logic [XLEN-1:0] LIM = XLEN'(4 * MEM_SIZE);

    logic      if_ok, d_ok;
    logic      if_win, d_win;
    arb_resp_t r, r_nxt;

    assign if_ok = (if_addr < LIM);
    assign d_ok  = (d_addr < LIM);

`ifdef MEM_ARB_FAIRNESS_EN
    logic hit;

    arb_starve_cnt #(.MAX(STARVE_MAX)) u_starve (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (if_req),
        .win   (if_win),
        .hit   (hit)
    );

    assign if_win = rst_n & if_req & (~d_req | hit);
`else
    assign if_win = rst_n & if_req & ~d_req;
`endif

    // Grants are masked while reset is held so every output reads 0.
    assign d_win  = rst_n & d_req & ~if_win;
    assign if_gnt = if_win;
    assign d_gnt  = d_win;

    always_comb begin
        r_nxt     = '{own: OWN_NONE, err: 1'b0, zero: 1'b0};
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_be    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        unique case (1'b1)
            if_win: begin
                r_nxt.own  = OWN_IF;
                r_nxt.err  = ~if_ok;
                r_nxt.zero = ~if_ok;
                mem_en     = if_ok;
                mem_be     = 4'hF;
                mem_addr   = if_addr[2 +: AW];
            end
            d_win: begin
                r_nxt.own  = OWN_D;
                r_nxt.err  = ~d_ok;
                r_nxt.zero = ~d_ok | d_we;
                mem_en     = d_ok;
                mem_we     = d_ok & d_we;
                mem_be     = d_be;
                mem_addr   = d_addr[2 +: AW];
                mem_wdata  = d_wdata;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r <= '{own: OWN_NONE, err: 1'b0, zero: 1'b0};
        end else begin
            r <= r_nxt;
        end
    end

    assign if_rvalid = (r.own == OWN_IF);
    assign d_rvalid  = (r.own == OWN_D);
    assign if_err    = if_rvalid & r.err;
    assign d_err     = d_rvalid & r.err;
    assign if_rdata  = (if_rvalid && !r.zero) ? mem_rdata : '0;
    assign d_rdata   = (d_rvalid && !r.zero) ? mem_rdata : '0;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single-port, word-wide instruction/data memory between the fetch stage and the load/store unit of the RV32I core. Arbitrates one access per cycle, drives the memory, routes the 1-cycle-latency read data back to its owner, and rejects out-of-range addresses with an error response. Sits between the core pipeline and the memory array sized by `MEM_SIZE`.

## Interface
- `MEM_SIZE`, 4000: memory depth in 32-bit words.
- `XLEN`, `BIN_DIG` (32): data/address width.
- `STARVE_MAX`, 4: consecutive fetch losses before fetch is forced to win (fairness build only).

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `if_req` in 1 / `if_addr` in XLEN: fetch request, byte address.
- `if_gnt` out 1 / `if_rvalid` out 1 / `if_rdata` out XLEN / `if_err` out 1: fetch grant, response, data, range error.
- `d_req` in 1 / `d_we` in 1 / `d_addr` in XLEN / `d_be` in 4 / `d_wdata` in XLEN: data request (store when `d_we`).
- `d_gnt` out 1 / `d_rvalid` out 1 / `d_rdata` out XLEN / `d_err` out 1: data grant, response, data, range error.
- `mem_en` out 1 / `mem_we` out 1 / `mem_be` out 4 / `mem_addr` out `$clog2(MEM_SIZE)` / `mem_wdata` out XLEN: memory command.
- `mem_rdata` in XLEN: memory read data, valid the cycle after `mem_en`.

## Operation
- Request/grant: requester holds `*_req` and fields stable until `*_gnt`; grant is combinational in the request cycle; at most one grant per cycle.
- Default priority: data over fetch (strict).
- Word address = `addr[2 +: $clog2(MEM_SIZE)]`; `addr[1:0]` ignored (alignment is the LSU's job). Fetch always reads with `mem_be`=4'hF, `mem_we`=0.
- Range check: `addr >= 4*MEM_SIZE` → request still granted, `mem_en`=0, response next cycle with `*_err`=1, `*_rdata`=0.
- Owner register (`OWN_NONE`/`OWN_IF`/`OWN_D`) plus err flag captured at grant; next cycle routes `mem_rdata` to the owner's `*_rdata` with `*_rvalid`=1; the other port's rdata is 0.
- Stores: `d_rvalid` asserted next cycle as write ack, `d_rdata`=0.
- Pipelined: a new grant may issue in the same cycle as the previous response; sustained throughput one access/cycle.
- Reset: all outputs 0, owner=`OWN_NONE`, starvation counter 0. Reset asserted mid-access drops the pending response (no `*_rvalid` after release).

## Timing
- Cycle N: `*_req`&`*_gnt`, `mem_en`=1 (if in range). Cycle N+1: `*_rvalid`, `*_rdata`/`*_err`. Latency exactly 1.
- Simultaneous `if_req`&`d_req`: data granted (unless fairness override); fetch sees `if_gnt`=0 and retries.
- `*_rvalid` never asserted without a grant in the previous cycle; never two rvalids in one cycle.

## Configuration
- `MEM_ARB_FAIRNESS_EN` defined: counter increments each cycle fetch requests and loses, clears on fetch grant or no fetch request; when counter = `STARVE_MAX`, fetch wins over data that cycle.
- Undefined: strict data priority; counter and `STARVE_MAX` unused; fetch may starve indefinitely.

## Structure
- Shared package `defs`: `MEM_SIZE`, `BIN_DIG`, `MEM_ADDR_W = $clog2(MEM_SIZE)`, `arb_owner_t` enum (`OWN_NONE`, `OWN_IF`, `OWN_D`).
- One sub-module `arb_starve_cnt` (saturating counter, `hit` output), instantiated only under `MEM_ARB_FAIRNESS_EN`.

## Test plan
- Fetch only, `if_addr`=0x10, mem word 4 = 0xDEADBEEF → `if_gnt` same cycle, `mem_addr`=4, next cycle `if_rvalid`=1, `if_rdata`=0xDEADBEEF.
- Store `d_addr`=0x20, `d_be`=4'b0011, `d_wdata`=0x1234ABCD then load 0x20 → `mem_we`=1,`mem_be`=0011,`mem_addr`=8; ack next cycle `d_rdata`=0; load returns 0x????ABCD with upper half preserved.
- Both request every cycle for 10 cycles → without macro fetch never granted; with `MEM_ARB_FAIRNESS_EN`, `STARVE_MAX`=4: fetch granted on cycles 5 and 10.
- `d_addr`=16000 (=4*MEM_SIZE) → `d_gnt`=1, `mem_en`=0, next cycle `d_rvalid`=1, `d_err`=1, `d_rdata`=0.
- Back-to-back loads 0x0,0x4,0x8 → one rvalid per cycle, in order, matching memory contents.
- `rst_n` low in cycle after grant → no `*_rvalid`, all outputs 0; first access after release behaves normally.
